// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path: ALU control
// codes, FSM states, opcodes and datapath mux select encodings.
package riscv_pkg;

    // ALU operation codes, shared with the ALU itself.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM, refined by the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // True when the opcode/funct combination is one this core executes.
    function automatic logic instr_legal(input logic [6:0] opcode,
                                         input logic [2:0] funct3,
                                         input logic       funct7b5);
        logic alu_f3_ok;
        alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);
        case (opcode)
            OP_LOAD, OP_STORE: return funct3 == 3'b010;
            OP_RTYPE:          return alu_f3_ok && (!funct7b5 || funct3 == 3'b000);
            OP_ITYPE:          return alu_f3_ok;
            OP_BRANCH:         return funct3 == 3'b000;
            OP_JAL:            return 1'b1;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the control FSM and the multicycle datapath: decoded
// instruction fields and status come in, mux selects and enables go out.
interface multicycle_controller_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic [2:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;

    // Controller side.
    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output alu_control, alu_src_a, alu_src_b, result_src, imm_src,
               adr_src, ir_write, pc_write, reg_write, mem_write, illegal
    );

    // Datapath side.
    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  alu_control, alu_src_a, alu_src_b, result_src, imm_src,
               adr_src, ir_write, pc_write, reg_write, mem_write, illegal
    );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's coarse ALU request plus the
// instruction's funct fields into the ALU operation code.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Map ALU request and funct fields to an ALU operation.
    always_comb begin
        // NOTE: default first so every path assigns alu_control and no latch is inferred.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM. Registers only the state; every output is
// decoded combinationally from the state, with mem_ready/zero gating the
// PC and IR enables and the funct fields refining the ALU operation.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus
);

    state_t  state;
    state_t  state_next;
    alu_op_t alu_op;

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            // NOTE: non-blocking so the register samples pre-edge values like every other flop.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (!instr_legal(bus.opcode, bus.funct3, bus.funct7b5)) begin
                    state_next = S_ERROR;
                end else begin
                    case (bus.opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_RTYPE:          state_next = S_EXECR;
                        OP_ITYPE:          state_next = S_EXECI;
                        OP_BRANCH:         state_next = S_BEQ;
                        OP_JAL:            state_next = S_JAL;
                        default:           state_next = S_ERROR;
                    endcase
                end
            end
            S_MEMADR:   state_next = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_ERROR:    state_next = S_ERROR;
            default:    state_next = S_ERROR;
        endcase
    end

    // Per-state datapath selects and enables.
    always_comb begin
        alu_op         = ALUOP_ADD;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RD2;
        bus.result_src = RES_ALUOUT;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_write  = 1'b0;
        bus.illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALURESULT;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RD1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  bus.adr_src = 1'b1;
            S_MEMWB: begin
                bus.result_src = RES_DATA;
                bus.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RD1;
                alu_op        = ALUOP_FUNCT;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RD1;
                bus.alu_src_b = SRCB_IMM;
                alu_op        = ALUOP_FUNCT;
            end
            S_ALUWB:    bus.reg_write = 1'b1;
            S_BEQ: begin
                bus.alu_src_a = SRCA_RD1;
                alu_op        = ALUOP_SUB;
                bus.pc_write  = bus.zero;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                bus.pc_write  = 1'b1;
            end
            S_ERROR:    bus.illegal = 1'b1;
            default:    bus.illegal = 1'b1;
        endcase
    end

    // Immediate format follows the instruction, independent of state.
    always_comb begin
        case (bus.opcode)
            OP_STORE:  bus.imm_src = IMM_S;
            OP_BRANCH: bus.imm_src = IMM_B;
            OP_JAL:    bus.imm_src = IMM_J;
            default:   bus.imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.opcode[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (bus.alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes the
// hand-derived output vector for each cycle, the monitor pops and compares
// on every falling edge or on an asynchronous-reset sample event.
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0] alu_control;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
        logic       illegal;
    } outs_t;

    logic clk;
    logic rst_n;
    logic [1:0] cur_imm;
    int   checks = 0;
    int   errors = 0;
    string q_name[$];
    outs_t q_exp[$];
    event  sample_ev;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic outs_t mk(input logic [2:0] ac, input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [1:0] rs, input logic adr, input logic irw,
                                 input logic pcw, input logic rw, input logic mw, input logic ill);
        outs_t o;
        o.alu_control = ac;  o.alu_src_a = sa;  o.alu_src_b = sb;  o.result_src = rs;
        o.imm_src = 2'b00;   o.adr_src = adr;   o.ir_write = irw;  o.pc_write = pcw;
        o.reg_write = rw;    o.mem_write = mw;  o.illegal = ill;
        return o;
    endfunction

    function automatic outs_t e_fetch(input logic mr);
        return mk(3'b000, 2'b00, 2'b10, 2'b10, 1'b0, mr, mr, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_decode();
        return mk(3'b000, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_memadr();
        return mk(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_memread();
        return mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_memwb();
        return mk(3'b000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_memwrite();
        return mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic outs_t e_exec(input logic [2:0] ac, input logic [1:0] sb);
        return mk(ac, 2'b10, sb, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_aluwb();
        return mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_beq(input logic pcw);
        return mk(3'b001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, pcw, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_jal();
        return mk(3'b000, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic outs_t e_error();
        return mk(3'b000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    // Present new instruction fields; immediate format is hand-tabulated.
    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        case (op)
            7'b0100011: cur_imm = 2'b01;
            7'b1100011: cur_imm = 2'b10;
            7'b1101111: cur_imm = 2'b11;
            default:    cur_imm = 2'b00;
        endcase
    endtask

    task automatic push(input string name, input outs_t e);
        outs_t x;
        x = e;
        x.imm_src = cur_imm;
        q_name.push_back(name);
        q_exp.push_back(x);
    endtask

    // One clock cycle: inputs change just after the rising edge.
    task automatic step(input string name, input logic mr, input logic z, input outs_t e);
        @(posedge clk);
        #1;
        bus.mem_ready = mr;
        bus.zero      = z;
        push(name, e);
    endtask

    // A FETCH cycle that also presents the next instruction's fields.
    task automatic fetch(input string name, input logic mr,
                         input logic [6:0] op, input logic [2:0] f3, input logic f7);
        @(posedge clk);
        #1;
        set_instr(op, f3, f7);
        bus.mem_ready = mr;
        bus.zero      = 1'b0;
        push(name, e_fetch(mr));
    endtask

    // Assert reset between edges and sample without any clock edge.
    task automatic reset_sample(input string name, input logic mr);
        rst_n         = 1'b0;
        bus.mem_ready = mr;
        #1;
        push(name, e_fetch(mr));
        -> sample_ev;
        #1;
    endtask

    initial begin : monitor
        string nm;
        outs_t ex;
        outs_t act;
        forever begin
            @(negedge clk or sample_ev);
            if (q_exp.size() != 0) begin
                nm = q_name.pop_front();
                ex = q_exp.pop_front();
                act.alu_control = bus.alu_control;
                act.alu_src_a   = bus.alu_src_a;
                act.alu_src_b   = bus.alu_src_b;
                act.result_src  = bus.result_src;
                act.imm_src     = bus.imm_src;
                act.adr_src     = bus.adr_src;
                act.ir_write    = bus.ir_write;
                act.pc_write    = bus.pc_write;
                act.reg_write   = bus.reg_write;
                act.mem_write   = bus.mem_write;
                act.illegal     = bus.illegal;
                checks++;
                if (act !== ex) begin
                    errors++;
                    $display("FAIL %s at %0t: got ac=%b sa=%b sb=%b rs=%b imm=%b adr=%b ir=%b pc=%b rw=%b mw=%b ill=%b, required ac=%b sa=%b sb=%b rs=%b imm=%b adr=%b ir=%b pc=%b rw=%b mw=%b ill=%b",
                             nm, $time,
                             act.alu_control, act.alu_src_a, act.alu_src_b, act.result_src, act.imm_src,
                             act.adr_src, act.ir_write, act.pc_write, act.reg_write, act.mem_write, act.illegal,
                             ex.alu_control, ex.alu_src_a, ex.alu_src_b, ex.result_src, ex.imm_src,
                             ex.adr_src, ex.ir_write, ex.pc_write, ex.reg_write, ex.mem_write, ex.illegal);
                end
            end
        end
    end

    initial begin : driver
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);          // add
        #2;
        reset_sample("reset_fetch", 1'b1);
        rst_n = 1'b1;

        // add: 4 cycles
        step("add_decode", 1'b1, 1'b0, e_decode());
        step("add_execr", 1'b1, 1'b0, e_exec(3'b000, 2'b00));
        step("add_aluwb", 1'b1, 1'b0, e_aluwb());
        // sub
        fetch("sub_fetch", 1'b1, 7'b0110011, 3'b000, 1'b1);
        step("sub_decode", 1'b1, 1'b0, e_decode());
        step("sub_execr", 1'b1, 1'b0, e_exec(3'b001, 2'b00));
        step("sub_aluwb", 1'b1, 1'b0, e_aluwb());
        // slti
        fetch("slti_fetch", 1'b1, 7'b0010011, 3'b010, 1'b0);
        step("slti_decode", 1'b1, 1'b0, e_decode());
        step("slti_execi", 1'b1, 1'b0, e_exec(3'b101, 2'b01));
        step("slti_aluwb", 1'b1, 1'b0, e_aluwb());
        // or
        fetch("or_fetch", 1'b1, 7'b0110011, 3'b110, 1'b0);
        step("or_decode", 1'b1, 1'b0, e_decode());
        step("or_execr", 1'b1, 1'b0, e_exec(3'b011, 2'b00));
        step("or_aluwb", 1'b1, 1'b0, e_aluwb());
        // addi with instr[30]=1 must still add (opcode[5]=0)
        fetch("addi_f7_fetch", 1'b1, 7'b0010011, 3'b000, 1'b1);
        step("addi_f7_decode", 1'b1, 1'b0, e_decode());
        step("addi_f7_execi", 1'b1, 1'b0, e_exec(3'b000, 2'b01));
        step("addi_f7_aluwb", 1'b1, 1'b0, e_aluwb());
        // andi
        fetch("andi_fetch", 1'b1, 7'b0010011, 3'b111, 1'b0);
        step("andi_decode", 1'b1, 1'b0, e_decode());
        step("andi_execi", 1'b1, 1'b0, e_exec(3'b010, 2'b01));
        step("andi_aluwb", 1'b1, 1'b0, e_aluwb());
        // lw with two wait cycles in MEMREAD: 7 cycles
        fetch("lw_fetch", 1'b1, 7'b0000011, 3'b010, 1'b0);
        step("lw_decode", 1'b1, 1'b0, e_decode());
        step("lw_memadr", 1'b1, 1'b0, e_memadr());
        step("lw_memread_wait1", 1'b0, 1'b0, e_memread());
        step("lw_memread_wait2", 1'b0, 1'b0, e_memread());
        step("lw_memread_done", 1'b1, 1'b0, e_memread());
        step("lw_memwb", 1'b1, 1'b0, e_memwb());
        // beq taken, with one FETCH wait cycle first
        fetch("beq1_fetch_wait", 1'b0, 7'b1100011, 3'b000, 1'b0);
        fetch("beq1_fetch", 1'b1, 7'b1100011, 3'b000, 1'b0);
        step("beq1_decode", 1'b1, 1'b0, e_decode());
        step("beq1_taken", 1'b1, 1'b1, e_beq(1'b1));
        // beq not taken
        fetch("beq0_fetch", 1'b1, 7'b1100011, 3'b000, 1'b0);
        step("beq0_decode", 1'b1, 1'b0, e_decode());
        step("beq0_not_taken", 1'b1, 1'b0, e_beq(1'b0));
        // jal
        fetch("jal_fetch", 1'b1, 7'b1101111, 3'b000, 1'b0);
        step("jal_decode", 1'b1, 1'b0, e_decode());
        step("jal_jal", 1'b1, 1'b0, e_jal());
        step("jal_aluwb", 1'b1, 1'b0, e_aluwb());
        // sw, no waits: 4 cycles
        fetch("sw_fetch", 1'b1, 7'b0100011, 3'b010, 1'b0);
        step("sw_decode", 1'b1, 1'b0, e_decode());
        step("sw_memadr", 1'b1, 1'b0, e_memadr());
        step("sw_memwrite", 1'b1, 1'b0, e_memwrite());
        // unsupported opcode: ERROR held with zero/mem_ready toggling
        fetch("ecall_fetch", 1'b1, 7'b1110011, 3'b000, 1'b0);
        step("ecall_decode", 1'b1, 1'b0, e_decode());
        for (int i = 0; i < 10; i++) begin
            step($sformatf("error_hold_%0d", i), 1'(i % 2), 1'b1, e_error());
        end
        // async reset out of ERROR
        @(negedge clk);
        #1;
        set_instr(7'b0110011, 3'b010, 1'b1);          // R-type funct7b5=1 with funct3!=000
        reset_sample("reset_from_error", 1'b1);
        rst_n = 1'b1;
        step("badr_decode", 1'b1, 1'b0, e_decode());
        step("badr_error", 1'b1, 1'b0, e_error());
        step("badr_error_hold", 1'b1, 1'b0, e_error());
        // sw stalled in MEMWRITE, then reset mid-cycle
        @(negedge clk);
        #1;
        set_instr(7'b0100011, 3'b010, 1'b0);
        reset_sample("reset_before_sw", 1'b1);
        rst_n = 1'b1;
        step("sw2_decode", 1'b1, 1'b0, e_decode());
        step("sw2_memadr", 1'b1, 1'b0, e_memadr());
        step("sw2_memwrite_wait1", 1'b0, 1'b0, e_memwrite());
        step("sw2_memwrite_wait2", 1'b0, 1'b0, e_memwrite());
        @(negedge clk);
        #1;
        reset_sample("reset_mid_memwrite_ready_low", 1'b0);
        reset_sample("reset_mid_memwrite_ready_high", 1'b1);
        step("held_in_reset", 1'b1, 1'b0, e_fetch(1'b1));
        @(negedge clk);
        #1;
        set_instr(7'b0010011, 3'b000, 1'b0);          // addi
        rst_n = 1'b1;
        step("post_reset_decode", 1'b1, 1'b0, e_decode());
        step("post_reset_execi", 1'b1, 1'b0, e_exec(3'b000, 2'b01));
        step("post_reset_aluwb", 1'b1, 1'b0, e_aluwb());
        step("post_reset_fetch", 1'b1, 1'b0, e_fetch(1'b1));

        @(negedge clk);
        #1;
        if (q_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q_exp.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
